// File: rtl/window_apb_loader.sv
// APB initiator that loads the window_func coefficient table from an AXI-Stream:
// soft-reset the target, write FFT_SIZE coefficients, then arm it, polling status after each command.
module window_apb_loader #(
  parameter int FFT_SIZE   = 8192,
  parameter int APB_AW     = $clog2(FFT_SIZE-1)+3,
  parameter int POLL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              coef_tvalid,
  output logic              coef_tready,
  input  logic              coef_tlast,
  input  logic [31:0]       coef_tdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [APB_AW-1:0] paddr,
  output logic [31:0]       pwdata,
  input  logic [31:0]       prdata
);

  localparam int IW = $clog2(FFT_SIZE);
  localparam int PW = $clog2(POLL_LIMIT+1);
  localparam logic [IW-1:0]     LAST_IDX  = IW'(FFT_SIZE-1);
  localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE*4);
  localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'((FFT_SIZE+1)*4);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_WR, S_RST_POLL, S_LOAD, S_ARM_WR, S_ARM_POLL
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d, shadow_q, shadow_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [IW-1:0]     idx_q, idx_d, beat_idx;
  logic              tlast_bad_q, tlast_bad_d, err_q, err_d, done_q, done_d;
  logic              setup_ph, access_ph, hs, abort;
  logic              unused_prdata;

  assign setup_ph  = psel_q && !penable_q;
  assign access_ph = psel_q && penable_q;
  // While a write is in flight, a beat accepted in its access cycle belongs to the next index.
  assign beat_idx  = psel_q ? idx_q + IW'(1) : idx_q;
  assign coef_tready = (state_q == S_LOAD) &&
                       (!psel_q || (penable_q && idx_q != LAST_IDX && !tlast_bad_q));
  assign hs = coef_tvalid && coef_tready;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign unused_prdata = ^{prdata[31:10], prdata[7:0]};

  always_comb begin
    // NOTE: every _d gets a default first so no latch can be inferred.
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    shadow_d    = shadow_q;
    poll_d      = poll_q;
    idx_d       = idx_q;
    tlast_bad_d = tlast_bad_q;
    err_d       = err_q;
    done_d      = 1'b0;
    abort       = 1'b0;

    // A transfer always ends after its access cycle unless a state chains a new setup.
    if (setup_ph) penable_d = 1'b1;
    if (access_ph) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d       = 1'b0;
          idx_d       = '0;
          tlast_bad_d = 1'b0;
          state_d     = S_RST_WR;
        end
      end
      S_RST_WR, S_ARM_WR: begin
        if (!psel_q) begin
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          paddr_d  = CTRL_ADDR;
          pwdata_d = shadow_q ^ ((state_q == S_RST_WR) ? 32'h1 : 32'h100);
        end else if (access_ph) begin
          shadow_d = pwdata_q;
          poll_d   = '0;
          state_d  = (state_q == S_RST_WR) ? S_RST_POLL : S_ARM_POLL;
        end
      end
      S_RST_POLL, S_ARM_POLL: begin
        if (!psel_q) begin
          psel_d   = 1'b1;
          pwrite_d = 1'b0;
          paddr_d  = STAT_ADDR;
        end else if (access_ph) begin
          poll_d = poll_q + PW'(1);
          if (state_q == S_RST_POLL && prdata[9:8] == 2'd0) begin
            state_d = S_LOAD;
          end else if (state_q == S_ARM_POLL && prdata[9:8] == 2'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (poll_q == PW'(POLL_LIMIT-1)) begin
            abort = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (access_ph) begin
          if (tlast_bad_q)            abort   = 1'b1;
          else if (idx_q == LAST_IDX) state_d = S_ARM_WR;
          else                        idx_d   = idx_q + IW'(1);
        end
        if (hs) begin
          if (beat_idx == LAST_IDX && !coef_tlast) begin
            abort = 1'b1;
          end else begin
            psel_d      = 1'b1;
            penable_d   = 1'b0;
            pwrite_d    = 1'b1;
            paddr_d     = APB_AW'({beat_idx, 2'b00});
            pwdata_d    = coef_tdata;
            tlast_bad_d = coef_tlast && (beat_idx != LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      err_d     = 1'b1;
      state_d   = S_IDLE;
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      shadow_q    <= '0;
      poll_q      <= '0;
      idx_q       <= '0;
      tlast_bad_q <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      shadow_q    <= shadow_d;
      poll_q      <= poll_d;
      idx_q       <= idx_d;
      tlast_bad_q <= tlast_bad_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_window_apb_loader.sv
// Scoreboard bench for window_apb_loader: a small target model answers status reads,
// expected APB writes are queued by the stimulus and popped by a negedge monitor.
module tb_window_apb_loader;

  localparam int FFT = 8;
  localparam int AW  = 6;
  localparam int PL  = 4;
  localparam logic [AW-1:0] CTRL = 6'h20;
  localparam logic [AW-1:0] STAT = 6'h24;

  logic          clk = 1'b0;
  logic          rst, start;
  logic          coef_tvalid, coef_tready, coef_tlast;
  logic [31:0]   coef_tdata;
  logic          busy, done, err, psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0]   pwdata, prdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  window_apb_loader #(.FFT_SIZE(FFT), .POLL_LIMIT(PL)) dut (
    .clk(clk), .rst(rst), .start(start),
    .coef_tvalid(coef_tvalid), .coef_tready(coef_tready), .coef_tlast(coef_tlast),
    .coef_tdata(coef_tdata), .busy(busy), .done(done), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Target model: status[9:8] = 0 after a reset command, 1 after arm; 2 while settling or stuck.
  logic [31:0] tgt_ctrl;
  logic [1:0]  tgt_state;
  int          lag_cnt;
  int          lag_cfg = 1;
  bit          stuck   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      tgt_ctrl  <= 32'h0;
      tgt_state <= 2'd1;
      lag_cnt   <= 0;
    end else if (psel && penable) begin
      if (pwrite && paddr == CTRL) begin
        tgt_ctrl <= pwdata;
        if (pwdata[0] != tgt_ctrl[0]) begin
          tgt_state <= 2'd0;
          lag_cnt   <= lag_cfg;
        end else if (pwdata[8] != tgt_ctrl[8]) begin
          tgt_state <= 2'd1;
          lag_cnt   <= lag_cfg;
        end
      end else if (!pwrite && paddr == STAT && lag_cnt > 0) begin
        lag_cnt <= lag_cnt - 1;
      end
    end
  end

  assign prdata = (paddr == STAT) ? {22'd0, (stuck || lag_cnt > 0) ? 2'd2 : tgt_state, 8'd0}
                                  : 32'hDEAD_0000;

  // Monitor: protocol plus scoreboard of completed writes.
  int            cyc = 0;
  int            rd_cnt = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  logic          prev_setup = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (psel && penable) begin
      check("access_after_setup", 32'(prev_setup), 32'h1);
      check("addr_stable", 32'(paddr), 32'(prev_addr));
      if (pwrite) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, required no write", paddr, pwdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(paddr), 32'(e.addr));
          check("wr_data", pwdata, e.data);
        end
        if (paddr == 6'h00) first_cyc = cyc;
        if (paddr == 6'h1C) last_cyc  = cyc;
      end else begin
        check("rd_addr", 32'(paddr), 32'(STAT));
        rd_cnt++;
      end
    end
    prev_setup = psel && !penable;
    prev_addr  = paddr;
  end

  // Coefficient source; a new src_gen restarts it at beat 0.
  int          src_gen = 0;
  int          gen_seen = 0;
  int          beat = 0;
  int          tog_cnt = 0;
  int          src_tlast = FFT-1;
  bit          src_en = 1'b0;
  bit          src_toggle = 1'b0;
  bit          last_hs = 1'b0;
  logic [31:0] src_salt = 32'h0;

  always @(negedge clk) begin
    if (src_gen != gen_seen) begin
      gen_seen = src_gen;
      beat     = 0;
      tog_cnt  = 0;
      last_hs  = 1'b0;
    end else if (last_hs) begin
      beat++;
    end
    tog_cnt++;
    coef_tvalid = src_en && beat < FFT && (!src_toggle || ((tog_cnt / 3) % 2 == 0));
    coef_tdata  = src_salt ^ (32'(beat) * 32'h00010001);
    coef_tlast  = (beat == src_tlast);
    last_hs     = coef_tvalid && coef_tready;
  end

  logic [31:0] sh_m = 32'h0;

  task automatic push_wr(logic [AW-1:0] a, logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_cmd(logic [31:0] bitmask);
    sh_m = sh_m ^ bitmask;
    push_wr(CTRL, sh_m);
  endtask

  task automatic push_load(int n, logic [31:0] salt);
    for (int k = 0; k < n; k++) push_wr(AW'(k * 4), salt ^ (32'(k) * 32'h00010001));
  endtask

  task automatic begin_load(logic [31:0] salt, bit toggle, int tlast_beat);
    src_salt   = salt;
    src_toggle = toggle;
    src_tlast  = tlast_beat;
    src_en     = 1'b1;
    src_gen++;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1'b1; break; end
      if (err)  begin got_err  = 1'b1; break; end
    end
    if (!got_done && !got_err) begin
      checks++;
      errors++;
      $display("FAIL wait_end: no done or err within 3000 cycles, required one");
    end
  endtask

  task automatic expect_done(string tag);
    bit d, e;
    wait_end(d, e);
    check({tag, "_done"}, 32'(d), 32'h1);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_busy_at_done"}, 32'(busy), 32'h0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'h0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    src_en = 1'b0;
  endtask

  task automatic expect_err(string tag);
    bit d, e;
    wait_end(d, e);
    check({tag, "_err"}, 32'(e), 32'h1);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    repeat (10) @(negedge clk);
    check({tag, "_psel_idle"}, 32'(psel), 32'h0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'h0);
    src_en = 1'b0;
  endtask

  initial begin
    bit found;
    int rd0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {23'd0, psel, penable, pwrite, busy, done, err, coef_tready, 1'b0}, 32'h0);
    check("rst_paddr", 32'(paddr), 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full load at peak rate; a start issued mid-load must be ignored.
    push_cmd(32'h1);
    push_load(FFT, 32'h0);
    push_cmd(32'h100);
    begin_load(32'h0, 1'b0, FFT-1);
    repeat (2) @(negedge clk);
    check("t1_busy", 32'(busy), 32'h1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_done("t1");
    check("t1_cycles_per_word", 32'(last_cyc - first_cyc), 32'(2 * (FFT-1)));

    // Second load straight after: commands toggle from the stored shadow.
    push_cmd(32'h1);
    push_load(FFT, 32'hA5A5_0000);
    push_cmd(32'h100);
    begin_load(32'hA5A5_0000, 1'b0, FFT-1);
    expect_done("t5");

    // Bursty source.
    push_cmd(32'h1);
    push_load(FFT, 32'h1234_0000);
    push_cmd(32'h100);
    begin_load(32'h1234_0000, 1'b1, FFT-1);
    expect_done("t2");

    // Early tlast on beat 5: that beat is written, then error.
    push_cmd(32'h1);
    push_load(6, 32'h0);
    begin_load(32'h0, 1'b0, 5);
    expect_err("t3");

    // Missing tlast on the final beat: beat not written, error.
    push_cmd(32'h1);
    push_load(FFT-1, 32'h0);
    begin_load(32'h0, 1'b0, -1);
    expect_err("t3b");

    // Status stuck: exactly POLL_LIMIT reads, then error.
    stuck = 1'b1;
    push_cmd(32'h1);
    rd0 = rd_cnt;
    begin_load(32'h0, 1'b0, FFT-1);
    expect_err("t4");
    check("t4_reads", 32'(rd_cnt - rd0), 32'(PL));
    stuck = 1'b0;

    // Reset while the idx=3 write is in setup.
    push_cmd(32'h1);
    push_load(3, 32'h0);
    begin_load(32'h0, 1'b0, FFT-1);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (psel && !penable && paddr == 6'h0C) found = 1'b1;
    end
    check("t6_reached_idx3", 32'(found), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_psel", 32'(psel), 32'h0);
    check("t6_penable", 32'(penable), 32'h0);
    check("t6_tready", 32'(coef_tready), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    rst    = 1'b0;
    src_en = 1'b0;
    sh_m   = 32'h0;
    @(negedge clk);
    check("t6_queue_empty", 32'(exp_q.size()), 32'h0);
    push_cmd(32'h1);
    push_load(FFT, 32'h0F0F_0000);
    push_cmd(32'h100);
    begin_load(32'h0F0F_0000, 1'b0, FFT-1);
    expect_done("t6_rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
